// File: rtl/pipe_regs_pkg.sv
// -----------------------------------------------------------------------------
// pipe_regs
//   Shared types for the EX/MEM/WB forwarding pipeline.
//   data_fwd_t  : one pipeline/forwarding record (valid, rd, rf_wr_en,
//                 mem_read, rd_data)
//   BUBBLE      : all-zero record used for reset and inserted bubbles
//   LOAD_WAIT_W : width of the MEM-stage load wait counter
// -----------------------------------------------------------------------------
package pipe_regs;

  localparam int unsigned LOAD_WAIT_W = 8;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rf_wr_en;
    logic        mem_read;
    logic [31:0] rd_data;
  } data_fwd_t;

  localparam data_fwd_t BUBBLE = '0;

endpackage

// File: rtl/fwd_stage_reg.sv
// -----------------------------------------------------------------------------
// fwd_stage_reg
//   One data_fwd_t pipeline register with load / hold / bubble control.
//   Ports:
//     clk_i    : core clock
//     rst_i    : synchronous active-high reset (record cleared to BUBBLE)
//     load_i   : capture d_i
//     bubble_i : capture BUBBLE (wins over load_i)
//     d_i      : incoming record
//     q_o      : registered record
//   A captured record targeting x0 never carries a write enable, so no stage
//   downstream of this register can forward to or write x0.
// -----------------------------------------------------------------------------
module fwd_stage_reg
  import pipe_regs::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      load_i,
  input  logic      bubble_i,
  input  data_fwd_t d_i,
  output data_fwd_t q_o
);

  data_fwd_t rec_d;
  data_fwd_t rec_q;

  always_comb begin
    // NOTE: default-assign first so every path writes rec_d; no latch inferred.
    rec_d = rec_q;
    if (bubble_i) begin
      rec_d = BUBBLE;
    end else if (load_i) begin
      rec_d          = d_i;
      rec_d.rf_wr_en = d_i.rf_wr_en & (d_i.rd != 5'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignment; reset is synchronous
  // and every field of the record is cleared, not just valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) rec_q <= BUBBLE;
    else       rec_q <= rec_d;
  end

  assign q_o = rec_q;

endmodule

// File: rtl/fwd_source_pipe.sv
// -----------------------------------------------------------------------------
// fwd_source_pipe
//   EX -> MEM -> WB pipeline registers, EX/MEM forwarding records, register
//   file write port, load wait/timeout handling and upstream stall.
//   Parameter:
//     MAX_LOAD_WAIT (1..255) : cycles a load may wait in MEM for rvalid before
//                              it is retired with rd_data=0 and load_err_o.
//   Inputs : clk_i, rst_i (sync, active high), id_* decode fields,
//            load_use_hazard_i, flush_i, ex_result_i, dmem_rvalid_i/rdata_i
//   Outputs: ex_stage_o, mem_stage_o (forwarding records), stall_o
//            (combinational), rf_wr_en_o/rf_rd_o/rf_wr_data_o (from WB),
//            load_err_o (one-cycle timeout pulse)
//   Build option: define FWD_WB_STAGE_EN to add wb_stage_o exposing the WB
//   record for a third forwarding tier.
// -----------------------------------------------------------------------------
module fwd_source_pipe
  import pipe_regs::*;
#(
  parameter int unsigned MAX_LOAD_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_rf_wr_en_i,
  input  logic        id_mem_read_i,
  input  logic        load_use_hazard_i,
  input  logic        flush_i,
  input  logic [31:0] ex_result_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output data_fwd_t   ex_stage_o,
  output data_fwd_t   mem_stage_o,
  output logic        stall_o,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wr_data_o,
  output logic        load_err_o
`ifdef FWD_WB_STAGE_EN
  ,
  output data_fwd_t   wb_stage_o
`endif
);

  localparam logic [LOAD_WAIT_W-1:0] WAIT_LAST = LOAD_WAIT_W'(MAX_LOAD_WAIT - 1);

  data_fwd_t ex_q, mem_q, wb_q;
  data_fwd_t ex_d, mem_d, wb_d;

  logic                   load_done_d, load_done_q;
  logic [LOAD_WAIT_W-1:0] wait_cnt_d,  wait_cnt_q;

  logic mem_unfinished;
  logic advance;
  logic load_timeout;
  logic id_take;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_unfinished = mem_q.valid & mem_q.mem_read & ~load_done_q;
    advance        = ~mem_unfinished | dmem_rvalid_i;
    load_timeout   = mem_unfinished & ~dmem_rvalid_i & (wait_cnt_q == WAIT_LAST);
    // Flush and hazard both yield the same bubble, so their priority is moot.
    id_take        = id_valid_i & ~flush_i & ~load_use_hazard_i;

    ex_d          = BUBBLE;
    ex_d.valid    = 1'b1;
    ex_d.rd       = id_rd_i;
    ex_d.rf_wr_en = id_rf_wr_en_i;
    ex_d.mem_read = id_mem_read_i;

    // MEM is rewritten every cycle: either the new EX instruction or its own
    // contents updated by a load timeout. rvalid on a pending load always
    // advances, so MEM never needs to capture load data while holding.
    if (advance) begin
      mem_d         = ex_q;
      mem_d.rd_data = ex_result_i;
    end else begin
      mem_d = mem_q;
      if (load_timeout) mem_d.rd_data = '0;
    end

    wb_d = mem_q;
    if (mem_unfinished && dmem_rvalid_i) wb_d.rd_data = dmem_rdata_i;

    load_done_d = load_done_q;
    wait_cnt_d  = wait_cnt_q;
    if (advance) begin
      load_done_d = 1'b0;
      wait_cnt_d  = '0;
    end else if (load_timeout) begin
      load_done_d = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_done_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      load_done_q <= load_done_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  fwd_stage_reg u_ex_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (advance & id_take),
    .bubble_i (advance & ~id_take),
    .d_i      (ex_d),
    .q_o      (ex_q)
  );

  fwd_stage_reg u_mem_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (1'b1),
    .bubble_i (1'b0),
    .d_i      (mem_d),
    .q_o      (mem_q)
  );

  // A bubble on hold keeps the retiring instruction from writing twice.
  fwd_stage_reg u_wb_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (advance),
    .bubble_i (~advance),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_stage_o         = ex_q;
    ex_stage_o.rd_data = ex_result_i;
  end

  assign mem_stage_o  = mem_q;
  assign stall_o      = ~rst_i & (~advance | load_use_hazard_i);
  assign load_err_o   = ~rst_i & load_timeout;
  assign rf_wr_en_o   = ~rst_i & wb_q.valid & wb_q.rf_wr_en;
  assign rf_rd_o      = wb_q.rd;
  assign rf_wr_data_o = wb_q.rd_data;

`ifdef FWD_WB_STAGE_EN
  assign wb_stage_o = wb_q;
`endif

endmodule

// File: tb/tb_fwd_source_pipe.sv
// -----------------------------------------------------------------------------
// tb_fwd_source_pipe
//   Directed bench for fwd_source_pipe. Two instances share all inputs: dut
//   uses the default MAX_LOAD_WAIT (255), dut3 uses MAX_LOAD_WAIT=3 for the
//   timeout scenario. Inputs change 1 time unit after posedge; outputs are
//   sampled 2 units later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fwd_source_pipe;
  import pipe_regs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rd;
  logic        id_wr;
  logic        id_mr;
  logic        hazard;
  logic        flush;
  logic [31:0] ex_result;
  logic        rvalid;
  logic [31:0] rdata;

  data_fwd_t   ex_o, mem_o, ex3, mem3;
  logic        stall, stall3, rf_en, rf_en3, err, err3;
  logic [4:0]  rf_rd, rf_rd3;
  logic [31:0] rf_data, rf_data3;
`ifdef FWD_WB_STAGE_EN
  data_fwd_t   wb_o, wb3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fwd_source_pipe dut (
    .clk_i (clk), .rst_i (rst),
    .id_valid_i (id_valid), .id_rd_i (id_rd), .id_rf_wr_en_i (id_wr),
    .id_mem_read_i (id_mr), .load_use_hazard_i (hazard), .flush_i (flush),
    .ex_result_i (ex_result), .dmem_rvalid_i (rvalid), .dmem_rdata_i (rdata),
    .ex_stage_o (ex_o), .mem_stage_o (mem_o), .stall_o (stall),
    .rf_wr_en_o (rf_en), .rf_rd_o (rf_rd), .rf_wr_data_o (rf_data),
    .load_err_o (err)
`ifdef FWD_WB_STAGE_EN
    , .wb_stage_o (wb_o)
`endif
  );

  fwd_source_pipe #(.MAX_LOAD_WAIT(3)) dut3 (
    .clk_i (clk), .rst_i (rst),
    .id_valid_i (id_valid), .id_rd_i (id_rd), .id_rf_wr_en_i (id_wr),
    .id_mem_read_i (id_mr), .load_use_hazard_i (hazard), .flush_i (flush),
    .ex_result_i (ex_result), .dmem_rvalid_i (rvalid), .dmem_rdata_i (rdata),
    .ex_stage_o (ex3), .mem_stage_o (mem3), .stall_o (stall3),
    .rf_wr_en_o (rf_en3), .rf_rd_o (rf_rd3), .rf_wr_data_o (rf_data3),
    .load_err_o (err3)
`ifdef FWD_WB_STAGE_EN
    , .wb_stage_o (wb3)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rd, input logic wr, input logic mr);
    id_valid = v;
    id_rd    = rd;
    id_wr    = wr;
    id_mr    = mr;
  endtask

  task automatic idle(input int n);
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    hazard    = 1'b0;
    flush     = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    ex_result = '0;
    repeat (n) next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    settle();
    n_checks++; if (ex_o !== BUBBLE) begin n_fail++; $display("FAIL reset_ex: got %h want 0", ex_o); end
    n_checks++; if (mem_o !== BUBBLE) begin n_fail++; $display("FAIL reset_mem: got %h want 0", mem_o); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL reset_rf_en: got %b want 0", rf_en); end
    n_checks++; if ({rf_rd, rf_data} !== 37'd0) begin n_fail++; $display("FAIL reset_rf_addr_data: got %h/%h want 0/0", rf_rd, rf_data); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    drive_id(1'b1, 5'd5, 1'b1, 1'b0);
    settle();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_c0: got %b want 0", stall); end
    next_cycle();
    drive_id(1'b1, 5'd6, 1'b1, 1'b0);
    ex_result = 32'h1111_0005;
    settle();
    n_checks++; if (ex_o.valid !== 1'b1 || ex_o.rd !== 5'd5 || ex_o.rd_data !== 32'h1111_0005) begin n_fail++; $display("FAIL b2b_ex_c1: got v=%b rd=%0d d=%h want v=1 rd=5 d=11110005", ex_o.valid, ex_o.rd, ex_o.rd_data); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_c1: got %b want 0", stall); end
    next_cycle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    ex_result = 32'h2222_0006;
    settle();
    n_checks++; if (mem_o.valid !== 1'b1 || mem_o.rd !== 5'd5 || mem_o.rd_data !== 32'h1111_0005) begin n_fail++; $display("FAIL b2b_mem_c2: got v=%b rd=%0d d=%h want v=1 rd=5 d=11110005", mem_o.valid, mem_o.rd, mem_o.rd_data); end
    n_checks++; if (ex_o.rd !== 5'd6) begin n_fail++; $display("FAIL b2b_ex_c2: got rd=%0d want 6", ex_o.rd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_c2: got %b want 0", stall); end
    next_cycle();
    settle();
    n_checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'h1111_0005) begin n_fail++; $display("FAIL b2b_rf_c3: got en=%b rd=%0d d=%h want en=1 rd=5 d=11110005", rf_en, rf_rd, rf_data); end
    next_cycle();
    settle();
    n_checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd6 || rf_data !== 32'h2222_0006) begin n_fail++; $display("FAIL b2b_rf_c4: got en=%b rd=%0d d=%h want en=1 rd=6 d=22220006", rf_en, rf_rd, rf_data); end
    next_cycle();
    settle();
    n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL b2b_rf_c5: got en=%b want 0", rf_en); end
    idle(6);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    drive_id(1'b1, 5'd7, 1'b1, 1'b1);
    next_cycle();
    drive_id(1'b1, 5'd8, 1'b1, 1'b0);
    hazard    = 1'b1;
    ex_result = 32'h0000_0100;
    settle();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_hazard: got %b want 1", stall); end
    next_cycle();
    hazard = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hCAFE_0007;
    settle();
    n_checks++; if (ex_o.valid !== 1'b0) begin n_fail++; $display("FAIL lu_ex_bubble: got v=%b want 0", ex_o.valid); end
    n_checks++; if (mem_o.valid !== 1'b1 || mem_o.mem_read !== 1'b1 || mem_o.rd !== 5'd7) begin n_fail++; $display("FAIL lu_mem_load: got v=%b mr=%b rd=%0d want 1/1/7", mem_o.valid, mem_o.mem_read, mem_o.rd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_rvalid: got %b want 0", stall); end
    next_cycle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    rvalid = 1'b0;
    settle();
    n_checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hCAFE_0007) begin n_fail++; $display("FAIL lu_rf_write: got en=%b rd=%0d d=%h want en=1 rd=7 d=cafe0007", rf_en, rf_rd, rf_data); end
    n_checks++; if (ex_o.valid !== 1'b1 || ex_o.rd !== 5'd8) begin n_fail++; $display("FAIL lu_dep_in_ex: got v=%b rd=%0d want v=1 rd=8", ex_o.valid, ex_o.rd); end
    idle(6);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_late_load();
    drive_id(1'b1, 5'd9, 1'b1, 1'b1);
    next_cycle();
    drive_id(1'b1, 5'd10, 1'b1, 1'b0);
    ex_result = 32'h0000_0200;
    next_cycle();
    drive_id(1'b1, 5'd11, 1'b1, 1'b0);
    ex_result = 32'h0000_000A;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL late_stall_w%0d: got %b want 1", i, stall); end
      n_checks++; if (ex_o.valid !== 1'b1 || ex_o.rd !== 5'd10 || mem_o.rd !== 5'd9 || mem_o.rd_data !== 32'h200) begin n_fail++; $display("FAIL late_hold_w%0d: got ex_rd=%0d mem_rd=%0d mem_d=%h want 10/9/200", i, ex_o.rd, mem_o.rd, mem_o.rd_data); end
      n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL late_rf_quiet_w%0d: got en=%b want 0", i, rf_en); end
      next_cycle();
    end
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    settle();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL late_stall_release: got %b want 0", stall); end
    n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL late_rf_quiet_rv: got en=%b want 0", rf_en); end
    next_cycle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    rvalid    = 1'b0;
    ex_result = 32'h0000_000B;
    settle();
    n_checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL late_rf_load: got en=%b rd=%0d d=%h want en=1 rd=9 d=deadbeef", rf_en, rf_rd, rf_data); end
    n_checks++; if (ex_o.rd !== 5'd11) begin n_fail++; $display("FAIL late_ex_next: got rd=%0d want 11", ex_o.rd); end
    next_cycle();
    settle();
    n_checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd10 || rf_data !== 32'h0000_000A) begin n_fail++; $display("FAIL late_rf_after1: got en=%b rd=%0d d=%h want en=1 rd=10 d=a", rf_en, rf_rd, rf_data); end
    next_cycle();
    settle();
    n_checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd11 || rf_data !== 32'h0000_000B) begin n_fail++; $display("FAIL late_rf_after2: got en=%b rd=%0d d=%h want en=1 rd=11 d=b", rf_en, rf_rd, rf_data); end
    idle(8);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_timeout();
    drive_id(1'b1, 5'd12, 1'b1, 1'b1);
    next_cycle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    ex_result = 32'h0000_0300;
    settle();
    n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL to_stall_pre: got %b want 0", stall3); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++; if (stall3 !== 1'b1 || err3 !== 1'b0) begin n_fail++; $display("FAIL to_wait_c%0d: got stall=%b err=%b want 1/0", i, stall3, err3); end
      next_cycle();
    end
    settle();
    n_checks++; if (err3 !== 1'b1 || stall3 !== 1'b1) begin n_fail++; $display("FAIL to_err_pulse: got err=%b stall=%b want 1/1", err3, stall3); end
    n_checks++; if (err !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL to_default_still_wait: got err=%b stall=%b want 0/1", err, stall); end
    next_cycle();
    settle();
    n_checks++; if (err3 !== 1'b0 || stall3 !== 1'b0 || mem3.rd_data !== 32'd0) begin n_fail++; $display("FAIL to_resume: got err=%b stall=%b d=%h want 0/0/0", err3, stall3, mem3.rd_data); end
    next_cycle();
    rvalid = 1'b1;
    rdata  = 32'h0000_0077;
    settle();
    n_checks++; if (rf_en3 !== 1'b1 || rf_rd3 !== 5'd12 || rf_data3 !== 32'd0) begin n_fail++; $display("FAIL to_rf_zero: got en=%b rd=%0d d=%h want en=1 rd=12 d=0", rf_en3, rf_rd3, rf_data3); end
    n_checks++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL to_err_once: got %b want 0", err3); end
    next_cycle();
    rvalid = 1'b0;
    settle();
    n_checks++; if (rf_en3 !== 1'b0) begin n_fail++; $display("FAIL to_rf_single: got en=%b want 0", rf_en3); end
    n_checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd12 || rf_data !== 32'h77) begin n_fail++; $display("FAIL to_default_rf: got en=%b rd=%0d d=%h want en=1 rd=12 d=77", rf_en, rf_rd, rf_data); end
    idle(6);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush_x0();
    drive_id(1'b1, 5'd13, 1'b1, 1'b0);
    flush = 1'b1;
    next_cycle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    flush = 1'b0;
    settle();
    n_checks++; if (ex_o.valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_bubble: got v=%b want 0", ex_o.valid); end
    next_cycle();
    next_cycle();
    settle();
    n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL flush_no_write: got en=%b want 0", rf_en); end

    drive_id(1'b1, 5'd0, 1'b1, 1'b0);
    ex_result = 32'h0000_0099;
    next_cycle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    n_checks++; if (ex_o.valid !== 1'b1 || ex_o.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_ex: got v=%b wr=%b want 1/0", ex_o.valid, ex_o.rf_wr_en); end
    next_cycle();
    settle();
    n_checks++; if (mem_o.valid !== 1'b1 || mem_o.rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_mem: got v=%b wr=%b want 1/0", mem_o.valid, mem_o.rf_wr_en); end
    next_cycle();
    settle();
    n_checks++; if (rf_en !== 1'b0) begin n_fail++; $display("FAIL x0_rf: got en=%b want 0", rf_en); end
    idle(4);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_load();
    drive_id(1'b1, 5'd14, 1'b1, 1'b1);
    next_cycle();
    drive_id(1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    settle();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rml_pending: got stall=%b want 1", stall); end
    rst = 1'b1;
    settle();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rml_stall_in_reset: got %b want 0", stall); end
    next_cycle();
    rst    = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'h0000_0055;
    settle();
    n_checks++; if (ex_o !== BUBBLE || mem_o !== BUBBLE) begin n_fail++; $display("FAIL rml_cleared: got ex=%h mem=%h want 0/0", ex_o, mem_o); end
    n_checks++; if (stall !== 1'b0 || rf_en !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rml_outs: got stall=%b en=%b err=%b want 0/0/0", stall, rf_en, err); end
    next_cycle();
    rvalid = 1'b0;
    settle();
    n_checks++; if (rf_en !== 1'b0 || rf_data !== 32'd0 || rf_rd !== 5'd0) begin n_fail++; $display("FAIL rml_late_rvalid: got en=%b rd=%0d d=%h want 0/0/0", rf_en, rf_rd, rf_data); end
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    idle(0);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_late_load();
    test_load_timeout();
    test_flush_x0();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_source_pipe.md
Name: fwd_source_pipe

Overview:
- Produces the EX- and MEM-stage forwarding records (data_fwd_t) consumed by the core's per-source-register forwarders.
- Owns the EX→MEM→WB pipeline registers and the register-file write port.
- Acts on the load-use hazard and flush indications by inserting bubbles, and drives the upstream stall.
- Sits between the decode stage and the register file; the ALU and data memory are external.

Parameters:
- MAX_LOAD_WAIT, 255: maximum cycles a load may wait in MEM for dmem_rvalid_i before it is retired with an error; range 1..255.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  decode stage presents an instruction
- id_rd_i  in  5  destination register
- id_rf_wr_en_i  in  1  instruction writes rd
- id_mem_read_i  in  1  instruction is a load
- load_use_hazard_i  in  1  OR of all forwarder hazard outputs
- flush_i  in  1  taken branch/jump resolved in EX; kills the decode instruction
- ex_result_i  in  32  combinational ALU result for the EX instruction
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  32  load data
- ex_stage_o  out  data_fwd_t  EX forwarding record
- mem_stage_o  out  data_fwd_t  MEM forwarding record
- stall_o  out  1  hold IF/ID this cycle
- rf_wr_en_o  out  1  register-file write enable
- rf_rd_o  out  5  write address
- rf_wr_data_o  out  32  write data
- load_err_o  out  1  one-cycle pulse: load timed out

Behaviour:
- State:
  - EX, MEM and WB records, each holding valid, rd, rf_wr_en, mem_read and rd_data.
  - MEM additionally holds load_done and an 8-bit wait counter.
- Reset: all records have valid=0 and all fields 0; load_done=0; counter=0. While rst_i is high, rf_wr_en_o=0, load_err_o=0 and stall_o=0.
- mem_ready = !MEM.valid | !MEM.mem_read | MEM.load_done | dmem_rvalid_i.
- advance = mem_ready.
- stall_o = !advance | load_use_hazard_i. This path is combinational.
- On advance:
  - WB ← MEM. If dmem_rvalid_i is high in the same cycle for an unfinished load, WB.rd_data = dmem_rdata_i.
  - MEM ← EX with rd_data = ex_result_i; load_done=0; counter=0.
  - EX ← a bubble (valid=0) if flush_i | load_use_hazard_i | !id_valid_i; otherwise the ID fields.
  - Priority: flush_i over load_use_hazard_i. Both produce the same bubble.
- On !advance:
  - EX and MEM hold.
  - WB ← bubble, so no repeated register-file write.
  - flush_i is ignored. The upstream side holds flush_i until stall_o deasserts.
- Load wait:
  - While MEM holds an unfinished load, the counter increments each cycle.
  - dmem_rvalid_i captures dmem_rdata_i into MEM.rd_data and sets load_done.
  - When counter reaches MAX_LOAD_WAIT−1 without rvalid, load_done is forced, rd_data=0 and load_err_o pulses that cycle.
  - A dmem_rvalid_i arriving when no load is pending is ignored.
- x0: when captured, rd==0 forces rf_wr_en=0 in every record. No forwarding or write ever targets x0.
- Forwarding outputs:
  - ex_stage_o = EX fields with rd_data = ex_result_i.
  - mem_stage_o = MEM fields. For an unfinished load, valid is still presented; correctness comes from stall_o holding ID.
- Write port: rf_wr_en_o = WB.valid & WB.rf_wr_en; rf_rd_o = WB.rd; rf_wr_data_o = WB.rd_data. Each value is registered and lasts one cycle per retirement.
- Simultaneous events:
  - Hazard plus memory stall: hold takes effect, and no bubble enters until advance.
  - Reset mid-load discards the load; a late rvalid is ignored.

Optional Feature:
- Macro: FWD_WB_STAGE_EN.
- Defined: adds output wb_stage_o (data_fwd_t) exposing the WB record, for a third forwarding tier when the register file is not write-through.
- Undefined: the port is absent and the WB record stays internal.

Decomposition:
- pipe_regs package holds:
  - data_fwd_t: valid, rd[4:0], rf_wr_en, mem_read, rd_data[31:0]
  - a bubble constant (all-zero data_fwd_t)
  - a constant for the load-wait counter width (8)
- Natural sub-module: fwd_stage_reg.
  - One data_fwd_t register with synchronous reset and load/hold/bubble controls.
  - Instantiated three times.

Test Plan:
- Back-to-back ALU ops writing x5 then x6, no memory: ex_stage_o.rd=5 in cycle 1, mem_stage_o.rd=5 in cycle 2, rf_wr_en_o=1 with rf_rd_o=5 in cycle 3; stall_o stays 0 throughout.
- Load to x7 followed by load_use_hazard_i=1 for one cycle: stall_o=1 that cycle; the next EX record has valid=0; the load retires with its data; the dependent instruction enters EX one cycle later.
- Load with dmem_rvalid_i 4 cycles late, rdata=0xDEADBEEF: stall_o=1 for 4 cycles; EX and MEM hold; no rf writes during the wait; afterwards rf_wr_data_o=0xDEADBEEF exactly once.
- MAX_LOAD_WAIT=3 with rvalid never asserted: load_err_o pulses once; x rd is written with 0; the pipeline resumes.
- flush_i=1 together with id_valid_i=1: EX becomes a bubble and that instruction never reaches the rf write port. Separately, an instruction with rd=0 and rf_wr_en=1 shows rf_wr_en=0 in every record and rf_wr_en_o=0.
- rst_i asserted during a pending load, then rvalid arrives: all outputs are 0 and no rf write occurs.
